// File: rtl/fft_pkg.sv
// fft_pkg: definitions shared by the FFT streaming reorder buffer.
//   MAX_LOG2_N  largest supported log2 frame length
//   frame_len() frame length N derived from log2(N)
//   bitrev()    reverse the low 'width' bits of an index
//   rd_state_t  read-side FSM states
package fft_pkg;

    localparam int MAX_LOG2_N = 12;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    function automatic int frame_len(input int log2_n);
        return 1 << log2_n;
    endfunction

    // Mirror all MAX_LOG2_N bits, then shift the reversed field down so it
    // occupies bits [width-1:0]. The caller zero-extends its index and
    // truncates the result back to its own width.
    function automatic logic [MAX_LOG2_N-1:0] bitrev(
        input logic [MAX_LOG2_N-1:0] a,
        input int                    width
    );
        logic [MAX_LOG2_N-1:0] r;
        r = {<<{a}};
        return r >> (MAX_LOG2_N - width);
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two banks of 2**ADDR_W words, each word being {re, im}.
// The write port targets bank wr_bank. The read port always targets the
// other bank, so a write can never collide with a read.
//   clk      system clock
//   srst     synchronous active-high reset (clears the read register only)
//   we       write strobe
//   wr_bank  bank being filled
//   wr_addr  write address within the bank
//   wr_data  {re, im} word to store
//   rd_en    read strobe; rd_data holds its value while low
//   rd_addr  read address within the opposite bank
//   rd_data  registered read data (1-cycle latency)
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  we,
    input  logic                  wr_bank,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [2*DATA_W-1:0]   wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [2*DATA_W-1:0]   rd_data
);

    localparam int DEPTH = 2 * frame_len(ADDR_W);

    logic [2*DATA_W-1:0] mem [0:DEPTH-1];
    logic [2*DATA_W-1:0] rd_data_reg;

    // Contents are deliberately never cleared so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // The read register doubles as the buffer's output register. It only
    // loads on rd_en, which gives the hold-last-value behaviour outside bursts.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[{~wr_bank, rd_addr}];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: ping-pong frame buffer for the FFT streaming I/O.
// Samples are written in natural order. Each completed N-sample frame is
// replayed as a gapless burst, in bit-reversed or natural order, while the
// next frame fills the other bank.
//   clk           system clock
//   rst           synchronous active-high reset
//   write_enable  in_re/in_im carry a valid sample
//   in_re, in_im  input sample (two's complement, DATA_W bits each)
//   bitrev_en     readout order for the frame completing on this edge
//   out_re/out_im registered output sample
//   out_valid     out_re/out_im carry a frame sample
//   done          one-cycle pulse, the cycle before a burst's first out_valid
//   busy          read side is issuing addresses
// Supported LOG2_N range: 2..12.
module fft_reorder_buf
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              bitrev_en,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              out_valid,
    output logic              done,
    output logic              busy
);

    localparam logic [LOG2_N-1:0] LAST_IDX = '1;

    logic [LOG2_N-1:0]   wr_cnt_reg;
    logic                wr_bank_reg;
    logic                mode_reg;
    logic                done_reg;
    logic                out_valid_reg;
    logic                frame_done;

    rd_state_t           state_reg, state_next;
    logic [LOG2_N-1:0]   rd_cnt_reg, rd_cnt_next;
    logic                rd_en;
    logic [LOG2_N-1:0]   rd_addr;

    logic                ram_we;
    logic [2*DATA_W-1:0] ram_rd_data;

    // The last sample of a frame is being written on this edge.
    assign frame_done = write_enable && (wr_cnt_reg == LAST_IDX);

    // ---------------- write side and bank swap ----------------
    // wr_cnt is exactly LOG2_N bits wide, so N-1 wraps to 0 without an
    // explicit compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_reg  <= '0;
            wr_bank_reg <= 1'b0;
            mode_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= frame_done;
            if (write_enable) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
            if (frame_done) begin
                wr_bank_reg <= ~wr_bank_reg;
                mode_reg    <= bitrev_en;
            end
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rd_cnt_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_cnt_reg    <= rd_cnt_next;
            // The RAM read issued this cycle lands in the output register
            // at this edge, so valid trails READ by exactly one cycle.
            out_valid_reg <= (state_reg == READ);
        end
    end

    always_comb begin
        state_next  = state_reg;
        rd_cnt_next = rd_cnt_reg;
        rd_en       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_done) begin
                    state_next  = READ;
                    rd_cnt_next = '0;
                end
            end
            READ: begin
                rd_en       = 1'b1;
                rd_cnt_next = rd_cnt_reg + 1'b1;
                if (frame_done) begin
                    // A new frame completes on the last READ cycle. Restart
                    // at index 0 so the bursts run back to back.
                    state_next  = READ;
                    rd_cnt_next = '0;
                end else if (rd_cnt_reg == LAST_IDX) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next  = IDLE;
                rd_cnt_next = '0;
            end
        endcase
    end

    // mode_reg still holds the old frame's order on a swap edge, so the old
    // frame's final read keeps its own order.
    assign rd_addr = mode_reg ? LOG2_N'(bitrev(MAX_LOG2_N'(rd_cnt_reg), LOG2_N))
                              : rd_cnt_reg;

    // A sample presented during reset is not stored.
    assign ram_we = write_enable && !rst;

    fft_pingpong_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (LOG2_N)
    ) u_ram (
        .clk     (clk),
        .srst    (rst),
        .we      (ram_we),
        .wr_bank (wr_bank_reg),
        .wr_addr (wr_cnt_reg),
        .wr_data ({in_re, in_im}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    assign out_re    = ram_rd_data[2*DATA_W-1:DATA_W];
    assign out_im    = ram_rd_data[DATA_W-1:0];
    assign out_valid = out_valid_reg;
    assign done      = done_reg;
    assign busy      = (state_reg == READ);

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Testbench for fft_reorder_buf. Two instances are used: an 8-point buffer
// and a 1024-point buffer.
//
// For every completed frame the model works out a per-cycle timeline of
// expected outputs: done, busy, out_valid and the data word. A negedge
// process compares both DUTs against that timeline on every cycle. Literal
// checks pin the model to hand-computed orderings.
module tb_fft_reorder_buf;

    localparam int MAXC = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        we0, br0, we1, br1;
    logic [15:0] re0, im0, re1, im1;
    logic [15:0] ore0, oim0, ore1, oim1;
    logic        ov0, dn0, bz0, ov1, dn1, bz1;

    fft_reorder_buf #(.DATA_W(16), .LOG2_N(3)) u_dut8 (
        .clk(clk), .rst(rst), .write_enable(we0), .in_re(re0), .in_im(im0),
        .bitrev_en(br0), .out_re(ore0), .out_im(oim0), .out_valid(ov0),
        .done(dn0), .busy(bz0)
    );

    fft_reorder_buf #(.DATA_W(16), .LOG2_N(10)) u_dut1k (
        .clk(clk), .rst(rst), .write_enable(we1), .in_re(re1), .in_im(im1),
        .bitrev_en(br1), .out_re(ore1), .out_im(oim1), .out_valid(ov1),
        .done(dn1), .busy(bz1)
    );

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state
    logic [31:0] fbuf [2][4096];
    int          wcount [2];
    bit          exp_v [2][MAXC];
    bit          exp_done [2][MAXC];
    bit          exp_busy [2][MAXC];
    bit          exp_rst [2][MAXC];
    logic [31:0] exp_w [2][MAXC];
    logic [31:0] last_w [2];

    // Observation queues used by the literal checks
    logic [15:0] cap_re[$];
    logic [15:0] cap_im[$];
    int          done_q0[$];
    int          done_q1[$];
    int          vcount1 = 0;

    function automatic int rev_idx(input int j, input int bits);
        int r = 0;
        int x = j;
        for (int b = 0; b < bits; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic check(input string name, input int d, input int c,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, c, act, exp);
        end
    endtask

    // Model update for one rising edge, using the inputs sampled at that edge.
    // Timeline slot e is the interval that follows edge e.
    task automatic model_edge(input int d, input logic r, input logic w,
                              input logic [15:0] xr, input logic [15:0] xi,
                              input logic b);
        int n  = (d == 0) ? 8 : 1024;
        int lg = (d == 0) ? 3 : 10;
        if (r) begin
            wcount[d] = 0;
            exp_rst[d][cyc] = 1'b1;
            for (int i = cyc; i < MAXC; i++) begin
                exp_v[d][i]    = 1'b0;
                exp_done[d][i] = 1'b0;
                exp_busy[d][i] = 1'b0;
            end
        end else if (w) begin
            fbuf[d][wcount[d]] = {xr, xi};
            wcount[d]++;
            if (wcount[d] == n) begin
                wcount[d] = 0;
                exp_done[d][cyc] = 1'b1;
                for (int j = 0; j < n; j++) begin
                    int src = b ? rev_idx(j, lg) : j;
                    if (cyc + 1 + j < MAXC) begin
                        exp_busy[d][cyc + j]  = 1'b1;
                        exp_v[d][cyc + 1 + j] = 1'b1;
                        exp_w[d][cyc + 1 + j] = fbuf[d][src];
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge(0, rst, we0, re0, im0, br0);
        model_edge(1, rst, we1, re1, im1, br1);
        #1;
    endtask

    task automatic compare_dut(input int d, input logic v, input logic dn,
                               input logic bz, input logic [15:0] r,
                               input logic [15:0] i);
        if (exp_rst[d][cyc]) last_w[d] = '0;
        if (exp_v[d][cyc])   last_w[d] = exp_w[d][cyc];
        check("out_valid", d, cyc, 32'(v),  32'(exp_v[d][cyc]));
        check("done",      d, cyc, 32'(dn), 32'(exp_done[d][cyc]));
        check("busy",      d, cyc, 32'(bz), 32'(exp_busy[d][cyc]));
        check("out_data",  d, cyc, {r, i},  last_w[d]);
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            compare_dut(0, ov0, dn0, bz0, ore0, oim0);
            compare_dut(1, ov1, dn1, bz1, ore1, oim1);
            if (ov0) begin
                cap_re.push_back(ore0);
                cap_im.push_back(oim0);
            end
            if (dn0) done_q0.push_back(cyc);
            if (dn1) done_q1.push_back(cyc);
            if (ov1) vcount1++;
        end
    end

    int lit_br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int k;

    initial begin
        rst = 1'b1;
        we0 = 1'b0; br0 = 1'b0; re0 = '0; im0 = '0;
        we1 = 1'b0; br1 = 1'b0; re1 = '0; im1 = '0;

        // Reset held for 4 cycles while write_enable toggles
        for (int i = 0; i < 4; i++) begin
            we0 = i[0]; we1 = i[0];
            re0 = 16'(100 + i); re1 = 16'(100 + i);
            tick();
            if (i == 0) chk_en = 1'b1;
        end
        check("rst_out_valid", 0, cyc, 32'(ov0), 32'd0);
        check("rst_out_re",    0, cyc, 32'(ore0), 32'd0);
        check("rst_busy",      1, cyc, 32'(bz1), 32'd0);
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0;
        tick(); tick();

        // 8-point, bit-reversed, in_re = 0..7
        cap_re.delete(); cap_im.delete(); done_q0.delete();
        br0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            we0 = 1'b1; re0 = 16'(i); im0 = 16'd0;
            tick();
        end
        k = cyc;
        we0 = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("br8_count", 0, cyc, 32'(cap_re.size()), 32'd8);
        for (int j = 0; j < 8 && j < cap_re.size(); j++)
            check("br8_order", 0, j, 32'(cap_re[j]), 32'(lit_br[j]));
        check("br8_done_cycle", 0, cyc, (done_q0.size() == 1) ? done_q0[0] : -1, k);

        // 8-point, natural, in_re = 10..17, in_im = -1
        cap_re.delete(); cap_im.delete();
        br0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            we0 = 1'b1; re0 = 16'(10 + i); im0 = 16'hFFFF;
            tick();
        end
        we0 = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("nat8_count", 0, cyc, 32'(cap_re.size()), 32'd8);
        for (int j = 0; j < 8 && j < cap_re.size(); j++) begin
            check("nat8_re", 0, j, 32'(cap_re[j]), 32'(10 + j));
            check("nat8_im", 0, j, 32'(cap_im[j]), 32'h0000FFFF);
        end

        // 1024-point, three back-to-back frames, bit-reversed
        br1 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 1024; i++) begin
                we1 = 1'b1; re1 = 16'(f * 1024 + i); im1 = ~16'(i);
                tick();
                if (f == 0 && i == 1023) k = cyc;
            end
        end
        we1 = 1'b0;
        for (int i = 0; i < 1040; i++) tick();
        check("b2b_valid_count", 1, cyc, 32'(vcount1), 32'd3072);
        check("b2b_done_count", 1, cyc, 32'(done_q1.size()), 32'd3);
        for (int j = 1; j < done_q1.size(); j++)
            check("b2b_done_spacing", 1, j, 32'(done_q1[j] - done_q1[j-1]), 32'd1024);
        check("model_pin_w0", 1, k + 1, exp_w[1][k + 1][31:16], 32'd0);
        check("model_pin_w1", 1, k + 2, exp_w[1][k + 2][31:16], 32'd512);

        // Gapped input, bitrev_en toggling; frame 1 natural, frame 2 reversed
        cap_re.delete(); cap_im.delete();
        begin
            int cnt = 0;
            for (int t = 0; t < 32; t++) begin
                we0 = (t % 2 == 0);
                br0 = ((t / 6) % 2) != 0;
                re0 = 16'(200 + cnt); im0 = 16'(t);
                tick();
                if (t % 2 == 0) cnt++;
            end
        end
        we0 = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("gap_count", 0, cyc, 32'(cap_re.size()), 32'd16);
        if (cap_re.size() >= 16) begin
            check("gap_nat_1", 0, cyc, 32'(cap_re[1]), 32'd201);
            check("gap_rev_1", 0, cyc, 32'(cap_re[9]), 32'd212);
        end

        // Reset during READ cycle 3 of an 8-point readout
        br0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            we0 = 1'b1; re0 = 16'(300 + i); im0 = 16'd7;
            tick();
        end
        we0 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 0, cyc, 32'(ov0), 32'd0);
        check("midrst_busy",  0, cyc, 32'(bz0), 32'd0);
        cap_re.delete(); cap_im.delete();
        br0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            we0 = 1'b1; re0 = 16'(400 + i); im0 = 16'd9;
            tick();
        end
        we0 = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("fresh_count", 0, cyc, 32'(cap_re.size()), 32'd8);
        if (cap_re.size() >= 8) begin
            check("fresh_first", 0, cyc, 32'(cap_re[0]), 32'd400);
            check("fresh_last",  0, cyc, 32'(cap_re[7]), 32'd407);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_reorder_buf.md
Name: fft_reorder_buf

Overview:
- Parametrised ping-pong frame buffer for the FFT datapath: the streaming I/O stage generalised from the fixed 1024-point core.
- Accepts complex samples in natural order under write_enable and emits each completed frame as a contiguous N-sample burst.
- Output order is bit-reversed or natural, selected per frame.
- Double-banked, so frame k+1 is written while frame k is read out, with sustained one-sample-per-cycle throughput.

Parameters:
- DATA_W, 16, width of each of re/im, two's complement.
- LOG2_N, 10, log2 of frame length N (N = 2**LOG2_N, legal range 2..12).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- write_enable  in  1  current in_re/in_im is a valid sample.
- in_re  in  DATA_W  sample real part.
- in_im  in  DATA_W  sample imaginary part.
- bitrev_en  in  1  1 = bit-reversed readout, 0 = natural; sampled at the bank-swap edge.
- out_re  out  DATA_W  output real part, registered.
- out_im  out  DATA_W  output imaginary part, registered.
- out_valid  out  1  out_re/out_im hold a frame sample.
- done  out  1  one-cycle pulse, the cycle before a frame's first out_valid.
- busy  out  1  read side issuing addresses.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: out_re = 0, out_im = 0, out_valid = 0, done = 0, busy = 0, write counter = 0, read counter = 0, write bank = 0. Memory contents are not cleared.
- Write side:
  - On each edge with write_enable = 1, store {in_re, in_im} to the write bank at address wr_cnt, then wr_cnt increments.
  - Gaps with write_enable = 0 are allowed and hold wr_cnt.
  - When wr_cnt = N-1 is written, the frame is complete and wr_cnt wraps to 0.
- Bank swap (at the completing edge):
  - Write bank toggles; the completed bank becomes the read bank.
  - mode_r is loaded from bitrev_en.
  - The read FSM enters READ with rd_cnt = 0.
  - done = 1 in the following cycle.
- Read FSM states:
  - IDLE -> READ on frame completion.
  - READ issues address f(rd_cnt) each cycle, where f = bitrev over LOG2_N bits if mode_r = 1, else identity; rd_cnt increments.
  - READ -> IDLE after issuing rd_cnt = N-1, unless a frame completes on that same edge, in which case it re-enters READ (back-to-back).
  - busy = 1 exactly while in READ.
- Latency:
  - Sample N-1 is captured at edge k.
  - done is high during cycle k+1, the first READ cycle.
  - out_valid is high in cycles k+2 .. k+N+1, carrying mem[f(0)] .. mem[f(N-1)].
  - RAM read latency is 1 cycle, and the output register is that stage.
- Back-to-back frames:
  - The next frame completes no earlier than edge k+N, which is the last READ cycle, so the swap is always legal.
  - Output bursts are gapless; done for frame k+1 overlaps out_valid of frame k.
- out_re/out_im hold their last value when out_valid = 0.
- Simultaneous events: write_enable and reads always target different banks. A write and a swap on the same edge store the sample into the old write bank first.
- Reset mid-operation: the partial input frame and any in-flight readout are discarded, and outputs return to their reset values on the next edge.
- No arithmetic is performed; data passes bit-exact.

Decomposition:
- Shared package fft_pkg:
  - bitrev function, parametrised by width.
  - read FSM state enum {IDLE, READ}.
  - N derivation from LOG2_N.
- Sub-module fft_pingpong_ram:
  - 2 x N words of 2*DATA_W.
  - One write port with bank select; one registered read port on the opposite bank.
  - Inferred block RAM.

Test Plan:
- Reset sequence: hold rst = 1 for 4 cycles with write_enable toggling -> all outputs 0, no done, no writes retained in counters.
- LOG2_N=3, bitrev_en=1, write 0..7 to in_re and 0 to in_im -> done one cycle after the last write; out_re = 0,4,2,6,1,5,3,7 over 8 consecutive out_valid cycles.
- LOG2_N=3, bitrev_en=0, in_re = 10..17, in_im = -1 -> out_re = 10..17, out_im = -1 (16'hFFFF), out_valid exactly 8 cycles.
- LOG2_N=10, 3 frames back-to-back with continuous write_enable, in_re = frame*1024 + index, bitrev_en = 1 -> 3072 gapless out_valid cycles, each word matches bitrev over 10 bits, and done pulses are 1024 cycles apart.
- Gapped input (write_enable 50% duty) with bitrev_en toggled mid-frame -> order follows the bitrev_en value at the completing edge, and no output until the frame is full.
- rst asserted in READ cycle 3 of an 8-point readout -> out_valid = 0 from the next cycle; a fresh frame written afterwards is read out correctly from index 0.
